// File: rtl/pwm_pkg.sv
// PWM subsystem shared types and defaults.
// Used by the generator and the capture path.
package pwm_pkg;

  localparam int PWM_CNT_W = 16;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } pwm_cap_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Multi-flop synchronizer for an async input.
// Provides the synced level and its rise/fall strobes.
module pwm_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] sync_q;
  logic              s_d;

  // shift the async input through the chain, keep one delayed copy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_d};
      s_d    <= sync_q[STAGES-1];
    end
  end

  assign o_s    = sync_q[STAGES-1];
  assign o_rise = o_s & ~s_d;
  assign o_fall = ~o_s & s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of an
// incoming waveform and flags stuck-high/low inputs.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = PWM_CNT_W,
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pwm,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic [CNT_W-1:0] o_period_cnt,
  output logic             o_valid,
  output logic             o_stuck,
  output logic             o_stuck_lvl
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic s, rise, fall, edge_seen;

  pwm_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    (i_pwm),
    .o_s    (s),
    .o_rise (rise),
    .o_fall (fall)
  );

  assign edge_seen = rise | fall;

  pwm_cap_state_e   state, state_n;
  logic [CNT_W-1:0] hi_c, hi_n;
  logic [CNT_W-1:0] lo_c, lo_n;
  logic [CNT_W-1:0] idle_c, idle_n;
  logic [CNT_W-1:0] high_n, period_n;
  logic             valid_n, stuck_n, lvl_n;
  logic [CNT_W:0]   sum_w;
  logic [CNT_W-1:0] period_sat;
  logic             timeout_hit;

  assign sum_w      = {1'b0, hi_c} + {1'b0, lo_c};
  assign period_sat = sum_w[CNT_W] ? CNT_MAX
                                   : sum_w[CNT_W-1:0];

  // idle count sticks at its last value until an edge arrives
  assign timeout_hit = ~edge_seen & (idle_c == IDLE_LAST);

  // state, counters and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= WAIT_RISE;
      hi_c         <= '0;
      lo_c         <= '0;
      idle_c       <= '0;
      o_high_cnt   <= '0;
      o_period_cnt <= '0;
      o_valid      <= 1'b0;
      o_stuck      <= 1'b0;
      o_stuck_lvl  <= 1'b0;
    end else begin
      state        <= state_n;
      hi_c         <= hi_n;
      lo_c         <= lo_n;
      idle_c       <= idle_n;
      o_high_cnt   <= high_n;
      o_period_cnt <= period_n;
      o_valid      <= valid_n;
      o_stuck      <= stuck_n;
      o_stuck_lvl  <= lvl_n;
    end
  end

  // next-state: measurement FSM, then timeout overrides
  always_comb begin
    state_n  = state;
    hi_n     = hi_c;
    lo_n     = lo_c;
    idle_n   = idle_c;
    high_n   = o_high_cnt;
    period_n = o_period_cnt;
    valid_n  = 1'b0;
    stuck_n  = o_stuck;
    lvl_n    = o_stuck_lvl;

    if (edge_seen) begin
      idle_n = '0;
    end else if (idle_c != IDLE_LAST) begin
      idle_n = idle_c + 1'b1;
    end

    unique case (state)
      WAIT_RISE: begin
        if (rise) begin
          hi_n    = {{(CNT_W-1){1'b0}}, 1'b1};
          lo_n    = '0;
          state_n = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          lo_n    = {{(CNT_W-1){1'b0}}, 1'b1};
          state_n = LOW;
        end else if (s) begin
          hi_n = sat_inc(hi_c);
        end
      end
      LOW: begin
        if (rise) begin
          high_n   = hi_c;
          period_n = period_sat;
          valid_n  = 1'b1;
          hi_n     = {{(CNT_W-1){1'b0}}, 1'b1};
          lo_n     = '0;
          state_n  = HIGH;
        end else if (!s) begin
          lo_n = sat_inc(lo_c);
        end
      end
      default: begin
        state_n = WAIT_RISE;
      end
    endcase

    if (edge_seen) begin
      stuck_n = 1'b0;
      lvl_n   = 1'b0;
    end

    if (timeout_hit) begin
      stuck_n = 1'b1;
      lvl_n   = s;
      state_n = WAIT_RISE;
      hi_n    = '0;
      lo_n    = '0;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: directed PWM
// streams on a full-width and a 4-bit instance.
module tb_pwm_capture;

  typedef struct {
    int h;
    int p;
    int c;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic pwm_a, pwm_b;

  logic [15:0] a_high, a_period;
  logic        a_valid, a_stuck, a_lvl;
  logic [3:0]  b_high, b_period;
  logic        b_valid, b_stuck, b_lvl;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pwm_capture #(
    .CNT_W       (16),
    .TIMEOUT     (32),
    .SYNC_STAGES (2)
  ) u_a (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pwm        (pwm_a),
    .o_high_cnt   (a_high),
    .o_period_cnt (a_period),
    .o_valid      (a_valid),
    .o_stuck      (a_stuck),
    .o_stuck_lvl  (a_lvl)
  );

  pwm_capture #(
    .CNT_W       (4),
    .TIMEOUT     (15),
    .SYNC_STAGES (2)
  ) u_b (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pwm        (pwm_b),
    .o_high_cnt   (b_high),
    .o_period_cnt (b_period),
    .o_valid      (b_valid),
    .o_stuck      (b_stuck),
    .o_stuck_lvl  (b_lvl)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // drive a level for n cycles; optionally the rise closes a period
  task automatic lvl_a(input logic v, input int n, input bit push,
                       input int eh, input int ep);
    exp_t e;
    if (push) begin
      e = '{eh, ep, cyc + 3};
      qa.push_back(e);
    end
    pwm_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic lvl_b(input logic v, input int n, input bit push,
                       input int eh, input int ep);
    exp_t e;
    if (push) begin
      e = '{eh, ep, cyc + 3};
      qb.push_back(e);
    end
    pwm_b = v;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_valid) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_valid: unexpected pulse h=%0d p=%0d cyc=%0d",
                 a_high, a_period, cyc);
      end else begin
        e = qa.pop_front();
        if (a_high != 16'(e.h) || a_period != 16'(e.p) || cyc != e.c) begin
          errors++;
          $display("FAIL a_valid: got h=%0d p=%0d cyc=%0d expected h=%0d p=%0d cyc=%0d",
                   a_high, a_period, cyc, e.h, e.p, e.c);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_valid) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_valid: unexpected pulse h=%0d p=%0d cyc=%0d",
                 b_high, b_period, cyc);
      end else begin
        e = qb.pop_front();
        if (b_high != 4'(e.h) || b_period != 4'(e.p) || cyc != e.c) begin
          errors++;
          $display("FAIL b_valid: got h=%0d p=%0d cyc=%0d expected h=%0d p=%0d cyc=%0d",
                   b_high, b_period, cyc, e.h, e.p, e.c);
        end
      end
    end
  end

  initial begin
    rst   = 1'b1;
    pwm_a = 1'b0;
    pwm_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_high", int'(a_high), 0);
    chk("rst_period", int'(a_period), 0);
    chk("rst_valid", int'(a_valid), 0);
    chk("rst_stuck", int'(a_stuck), 0);
    chk("rst_lvl", int'(a_lvl), 0);
    rst = 1'b0;

    // stuck-low from reset: flag exactly TIMEOUT cycles later
    repeat (31) @(negedge clk);
    chk("stuck_lo_early", int'(a_stuck), 0);
    @(negedge clk);
    chk("stuck_lo_set", int'(a_stuck), 1);
    chk("stuck_lo_lvl", int'(a_lvl), 0);
    chk("b_stuck_lo_set", int'(b_stuck), 1);
    chk("b_stuck_lo_lvl", int'(b_lvl), 0);

    // steady 5/11: first rise ends stuck-low, no report
    lvl_a(1'b1, 5, 1'b0, 0, 0);
    chk("stuck_lo_clear", int'(a_stuck), 0);
    lvl_a(1'b0, 11, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      lvl_a(1'b1, 5, 1'b1, 5, 16);
      lvl_a(1'b0, 11, 1'b0, 0, 0);
    end

    // duty change to 12/4
    for (int i = 0; i < 3; i++) begin
      lvl_a(1'b1, 12, 1'b1, (i == 0) ? 5 : 12, 16);
      lvl_a(1'b0, 4, 1'b0, 0, 0);
    end

    // stuck-high
    lvl_a(1'b1, 34, 1'b1, 12, 16);
    chk("stuck_hi_early", int'(a_stuck), 0);
    @(negedge clk);
    chk("stuck_hi_set", int'(a_stuck), 1);
    chk("stuck_hi_lvl", int'(a_lvl), 1);
    chk("stuck_hi_keep_high", int'(a_high), 12);

    pwm_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("stuck_hi_hold", int'(a_stuck), 1);
    @(negedge clk);
    chk("stuck_hi_clear", int'(a_stuck), 0);
    chk("stuck_hi_lvl_clear", int'(a_lvl), 0);

    // recovery needs two rises
    lvl_a(1'b0, 5, 1'b0, 0, 0);
    lvl_a(1'b1, 5, 1'b0, 0, 0);
    lvl_a(1'b0, 11, 1'b0, 0, 0);
    lvl_a(1'b1, 1, 1'b1, 5, 16);
    lvl_a(1'b0, 1, 1'b0, 0, 0);

    // narrow 1/1 pulses
    for (int i = 0; i < 3; i++) begin
      lvl_a(1'b1, 1, 1'b1, 1, 2);
      lvl_a(1'b0, 1, 1'b0, 0, 0);
    end
    lvl_a(1'b1, 5, 1'b1, 1, 2);
    lvl_a(1'b0, 11, 1'b0, 0, 0);

    // reset mid-LOW discards the partial period
    lvl_a(1'b1, 5, 1'b1, 5, 16);
    lvl_a(1'b0, 5, 1'b0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_high", int'(a_high), 0);
    chk("mid_rst_period", int'(a_period), 0);
    chk("mid_rst_valid", int'(a_valid), 0);
    lvl_a(1'b0, 6, 1'b0, 0, 0);
    lvl_a(1'b1, 5, 1'b0, 0, 0);
    lvl_a(1'b0, 11, 1'b0, 0, 0);
    lvl_a(1'b1, 5, 1'b1, 5, 16);
    lvl_a(1'b0, 11, 1'b0, 0, 0);
    lvl_a(1'b1, 3, 1'b1, 5, 16);
    lvl_a(1'b0, 8, 1'b0, 0, 0);

    // saturation on the 4-bit instance: 3 + 13 clips to 15
    lvl_b(1'b1, 3, 1'b0, 0, 0);
    lvl_b(1'b0, 13, 1'b0, 0, 0);
    lvl_b(1'b1, 3, 1'b1, 3, 15);
    lvl_b(1'b0, 13, 1'b0, 0, 0);
    lvl_b(1'b1, 3, 1'b1, 3, 15);
    lvl_b(1'b0, 8, 1'b0, 0, 0);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
